// File: rtl/conv_window_gen_if.sv
// rtl/conv_window_gen_if.sv - pixel stream in / 3x3 window out bundle for conv_window_gen
interface conv_window_gen_if #(
  parameter int DATA_WIDTH = 8
);
  logic                    i_valid;
  logic                    i_sof;
  logic [DATA_WIDTH-1:0]   i_pixel;
  logic [9*DATA_WIDTH-1:0] o_window_packed;
  logic                    o_valid;
  logic                    o_frame_done;

  // Producer of pixels / consumer of windows.
  modport master (
    output i_valid, i_sof, i_pixel,
    input  o_window_packed, o_valid, o_frame_done
  );

  // The window generator itself.
  modport slave (
    input  i_valid, i_sof, i_pixel,
    output o_window_packed, o_valid, o_frame_done
  );
endinterface

// File: rtl/conv_window_gen.sv
// rtl/conv_window_gen.sv - raster pixel stream to sliding 3x3 window generator
module conv_window_gen #(
  parameter int DATA_WIDTH  = 8,
  parameter int FILTER_SIZE = 3,
  parameter int IMG_WIDTH   = 8,
  parameter int IMG_HEIGHT  = 8
) (
  input logic             clk,
  input logic             rst,
  conv_window_gen_if.slave bus
);
  // Only a 3x3 window is supported; FILTER_SIZE fixes the register geometry.
  localparam int NW = FILTER_SIZE * FILTER_SIZE;
  localparam int CW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
  localparam int RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;

  logic [CW-1:0] col, col_next, cur_col;
  logic [RW-1:0] row, row_next, cur_row;
  logic          accept;
  logic          win_ok;
  logic          win_last;

  logic [DATA_WIDTH-1:0] lb1 [IMG_WIDTH];
  logic [DATA_WIDTH-1:0] lb2 [IMG_WIDTH];
  logic [DATA_WIDTH-1:0] col_top, col_mid;

  logic [DATA_WIDTH-1:0]    win      [NW];
  logic [DATA_WIDTH-1:0]    win_next [NW];
  logic [NW*DATA_WIDTH-1:0] win_next_packed;

  assign accept = bus.i_valid;

  // Position of the pixel being accepted: a start-of-frame pixel is always (0,0).
  always_comb begin
    cur_col = col;
    cur_row = row;
    if (bus.i_sof) begin
      cur_col = '0;
      cur_row = '0;
    end
  end

  // Raster counters advance from the current position on each accepted pixel.
  always_comb begin
    col_next = col;
    row_next = row;
    if (accept) begin
      if (cur_col == CW'(IMG_WIDTH - 1)) begin
        col_next = '0;
        row_next = (cur_row == RW'(IMG_HEIGHT - 1)) ? '0 : cur_row + RW'(1);
      end else begin
        col_next = cur_col + CW'(1);
        row_next = cur_row;
      end
    end
  end

  // Counter state; reset returns to the top-left of a frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col <= '0;
      row <= '0;
    end else begin
      col <= col_next;
      row <= row_next;
    end
  end

  // Line buffers hold the two previous rows; contents are never cleared
  // because windows touching unwritten rows or columns are masked.
  always_ff @(posedge clk) begin
    if (accept) begin
      lb2[cur_col] <= lb1[cur_col];
      lb1[cur_col] <= bus.i_pixel;
    end
  end

  assign col_top = lb2[cur_col];
  assign col_mid = lb1[cur_col];

  // Next window: shift every row left one column, new column enters on the right.
  always_comb begin
    for (int i = 0; i < NW; i++) win_next[i] = win[i];
    if (accept) begin
      for (int ri = 0; ri < FILTER_SIZE; ri++) begin
        for (int ci = 0; ci < FILTER_SIZE - 1; ci++) begin
          win_next[ri*FILTER_SIZE + ci] = win[ri*FILTER_SIZE + ci + 1];
        end
      end
      win_next[FILTER_SIZE - 1]   = col_top;
      win_next[2*FILTER_SIZE - 1] = col_mid;
      win_next[NW - 1]            = bus.i_pixel;
    end
  end

  // Flatten the next window so element j lands at bits [j*DATA_WIDTH +: DATA_WIDTH].
  always_comb begin
    win_next_packed = '0;
    for (int i = 0; i < NW; i++) begin
      win_next_packed[i*DATA_WIDTH +: DATA_WIDTH] = win_next[i];
    end
  end

  // A window is complete only once two earlier rows and two earlier columns exist.
  always_comb begin
    win_ok   = accept && (cur_row >= RW'(2)) && (cur_col >= CW'(2));
    win_last = (cur_row == RW'(IMG_HEIGHT - 1)) && (cur_col == CW'(IMG_WIDTH - 1));
  end

  // Window shift register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NW; i++) win[i] <= '0;
    end else begin
      for (int i = 0; i < NW; i++) win[i] <= win_next[i];
    end
  end

  // Registered outputs; the packed window holds its value between valid cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.o_valid         <= 1'b0;
      bus.o_frame_done    <= 1'b0;
      bus.o_window_packed <= '0;
    end else begin
      bus.o_valid      <= win_ok;
      bus.o_frame_done <= win_ok && win_last;
      if (win_ok) bus.o_window_packed <= win_next_packed;
    end
  end
endmodule
